synch_responder: RTL and testbench

Design-side responder for the toggle-based synchronization handshake driven by the Teal verification side. The requester flips `req_toggle` after presenting `req_data`. This block detects the flip, captures the word, and returns `req_data + 1` on `rsp_data`. It then flips `ack_toggle` to acknowledge. It counts completed transactions and raises a sticky `test_done` after a configured count or after an idle timeout, which gives the testbench its exit condition.

---
 rtl/synch_pkg.sv | 13 +
 rtl/synch_toggle_detect.sv | 20 ++
 rtl/synch_responder.sv | 114 +++++++++++
 tb/tb_synch_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/synch_pkg.sv
// Shared types and sizing helpers for the toggle-handshake responder.
package synch_pkg;

   typedef enum logic [1:0] {IDLE, SERVE, DONE} synch_state_t;

   localparam int EVENT_W = 16;

   // Counter width able to hold 0..n; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/synch_toggle_detect.sv
// Toggle-change detector: remembers the last serviced toggle level and flags a
// new request whenever the live toggle differs from it.
module synch_toggle_detect (
   input  logic clk,
   input  logic reset,
   input  logic toggle,
   input  logic capture,
   output logic pending
);

   logic seen;

   always_ff @(posedge clk) begin
      if (reset)        seen <= 1'b0;
      else if (capture) seen <= toggle;
   end

   assign pending = (toggle != seen);

endmodule

// File: rtl/synch_responder.sv
// Responder for the toggle handshake: captures a request word, answers with
// word+1 and an ack flip, counts transactions and raises a sticky test_done.
module synch_responder
   import synch_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DONE_COUNT = 10,
   parameter int TIMEOUT    = 400
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_toggle,
   input  logic [DATA_W-1:0]  req_data,
   output logic               ack_toggle,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               busy,
   output logic [EVENT_W-1:0] event_count,
   output logic               test_done,
   output logic               timeout
);

   localparam int IDLE_W = cnt_w(TIMEOUT);
   localparam logic [IDLE_W-1:0]  TIMEOUT_V = IDLE_W'(TIMEOUT);
   localparam logic [EVENT_W-1:0] DONE_V    = EVENT_W'(DONE_COUNT);

   synch_state_t       state, state_nxt;
   logic               pending;
   logic               capture, serve, idle_inc, done_set, to_set;
   logic [DATA_W-1:0]  cap;
   logic [IDLE_W-1:0]  idle_cnt, idle_nxt;
   logic [EVENT_W-1:0] ev_nxt;

   synch_toggle_detect u_req_detect (
      .clk     (clk),
      .reset   (reset),
      .toggle  (req_toggle),
      .capture (capture),
      .pending (pending)
   );

   assign idle_nxt = idle_cnt + IDLE_W'(1);
   assign ev_nxt   = (event_count == {EVENT_W{1'b1}}) ? event_count
                                                      : event_count + EVENT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      serve     = 1'b0;
      idle_inc  = 1'b0;
      done_set  = 1'b0;
      to_set    = 1'b0;
      case (state)
         IDLE: begin
            // A pending request beats a timeout landing on the same edge.
            if (pending) begin
               capture   = 1'b1;
               state_nxt = SERVE;
            end else if (TIMEOUT != 0 && idle_nxt == TIMEOUT_V) begin
               to_set    = 1'b1;
               done_set  = 1'b1;
               state_nxt = DONE;
            end else begin
               idle_inc  = 1'b1;
            end
         end
         SERVE: begin
            serve = 1'b1;
            if (DONE_COUNT != 0 && ev_nxt == DONE_V) begin
               done_set  = 1'b1;
               state_nxt = DONE;
            end else begin
               state_nxt = IDLE;
            end
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cap         <= '0;
         idle_cnt    <= '0;
         rsp_data    <= '0;
         ack_toggle  <= 1'b0;
         busy        <= 1'b0;
         event_count <= '0;
         test_done   <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         if (capture) begin
            cap      <= req_data;
            busy     <= 1'b1;
            idle_cnt <= '0;
         end else if (idle_inc) begin
            idle_cnt <= idle_nxt;
         end
         if (serve) begin
            rsp_data    <= cap + DATA_W'(1);
            ack_toggle  <= ~ack_toggle;
            busy        <= 1'b0;
            event_count <= ev_nxt;
         end
         if (done_set) test_done <= 1'b1;
         if (to_set)   timeout   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_synch_responder.sv
// Directed bench for synch_responder with a timestamp-based reference model.
module tb_synch_responder;

   localparam int DATA_W     = 32;
   localparam int DONE_COUNT = 10;
   localparam int TIMEOUT    = 400;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_toggle;
   logic [DATA_W-1:0] req_data;
   logic              ack_toggle;
   logic [DATA_W-1:0] rsp_data;
   logic              busy;
   logic [15:0]       event_count;
   logic              test_done;
   logic              timeout;

   int total = 0;
   int bad   = 0;

   synch_responder #(.DATA_W(DATA_W), .DONE_COUNT(DONE_COUNT), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_toggle  (req_toggle),
      .req_data    (req_data),
      .ack_toggle  (ack_toggle),
      .rsp_data    (rsp_data),
      .busy        (busy),
      .event_count (event_count),
      .test_done   (test_done),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a request is either waiting, in service, or answered;
   // timeout is measured as elapsed edges since the last moment activity ended.
   bit                m_on = 0;
   int                cyc = 0;
   int                idle_start = 0;
   bit                m_seen, m_in_service, m_ack, m_done, m_to;
   logic [DATA_W-1:0] m_word, m_rsp;
   int                m_cnt;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_on = 1; m_seen = 0; m_in_service = 0; m_ack = 0; m_done = 0; m_to = 0;
         m_word = '0; m_rsp = '0; m_cnt = 0; idle_start = cyc;
      end else if (m_on && !m_done) begin
         if (m_in_service) begin
            m_rsp = m_word + 1;
            m_ack = !m_ack;
            m_in_service = 0;
            if (m_cnt < 65535) m_cnt++;
            if (DONE_COUNT != 0 && m_cnt == DONE_COUNT) m_done = 1;
            idle_start = cyc;
         end else if (req_toggle != m_seen) begin
            m_seen = req_toggle;
            m_word = req_data;
            m_in_service = 1;
         end else if (TIMEOUT != 0 && cyc - idle_start == TIMEOUT) begin
            m_done = 1;
            m_to = 1;
         end
      end
      #1;
      if (m_on) begin
         check("m_ack",   ack_toggle,  m_ack);
         check("m_rsp",   rsp_data,    m_rsp);
         check("m_busy",  busy,        m_in_service);
         check("m_count", event_count, m_cnt[15:0]);
         check("m_done",  test_done,   m_done);
         check("m_tout",  timeout,     m_to);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic ack0;
      reset = 1'b1; req_toggle = 1'b0; req_data = '0;
      tick(2);
      check("rst_ack",  ack_toggle, 0);
      check("rst_rsp",  rsp_data, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt",  event_count, 0);
      check("rst_done", test_done, 0);
      check("rst_tout", timeout, 0);
      reset = 1'b0;
      tick(1);

      // Single request: 5 -> 6 with two-edge latency.
      req_data = 32'h0000_0005; req_toggle = 1'b1;
      tick(1);
      check("t1_busy", busy, 1);
      check("t1_ack_early", ack_toggle, 0);
      tick(1);
      check("t1_ack", ack_toggle, 1);
      check("t1_rsp", rsp_data, 32'h6);
      check("t1_cnt", event_count, 1);
      check("t1_busy_lo", busy, 0);

      // All-ones wraps to zero.
      req_data = 32'hFFFF_FFFF; req_toggle = 1'b0;
      tick(2);
      check("t2_rsp", rsp_data, 0);
      check("t2_ack", ack_toggle, 0);
      check("t2_cnt", event_count, 2);
      check("t2_done", test_done, 0);

      // Eight more back-to-back requests reach the done count.
      for (int i = 0; i < 8; i++) begin
         req_data = 32'(100 + 3 * i); req_toggle = ~req_toggle;
         tick(1);
         check("t3_done_pre", test_done, 0);
         tick(1);
         check("t3_rsp", rsp_data, 32'(101 + 3 * i));
      end
      check("t3_done", test_done, 1);
      check("t3_cnt", event_count, 10);
      check("t3_tout", timeout, 0);
      ack0 = ack_toggle;
      req_data = 32'h55; req_toggle = ~req_toggle;
      tick(4);
      check("t3_no_ack", ack_toggle, ack0);
      check("t3_cnt_hold", event_count, 10);
      check("t3_busy", busy, 0);

      // Idle timeout after exactly TIMEOUT edges.
      reset = 1'b1; req_toggle = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(TIMEOUT - 1);
      check("t4_done_399", test_done, 0);
      check("t4_tout_399", timeout, 0);
      tick(1);
      check("t4_done_400", test_done, 1);
      check("t4_tout_400", timeout, 1);

      // A request arriving on the timeout edge wins.
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(TIMEOUT - 1);
      req_data = 32'h0000_00A0; req_toggle = 1'b1;
      tick(1);
      check("t5_busy", busy, 1);
      check("t5_tout", timeout, 0);
      tick(1);
      check("t5_ack", ack_toggle, 1);
      check("t5_rsp", rsp_data, 32'hA1);
      tick(3);
      check("t5_tout_late", timeout, 0);
      check("t5_done_late", test_done, 0);

      // Reset during service drops the request; held toggle is re-served.
      reset = 1'b1; req_toggle = 1'b0;
      tick(1);
      reset = 1'b0; req_data = 32'h0000_1234; req_toggle = 1'b1;
      tick(1);
      check("t6_busy", busy, 1);
      reset = 1'b1;
      tick(1);
      check("t6_ack_rst", ack_toggle, 0);
      check("t6_busy_rst", busy, 0);
      check("t6_rsp_rst", rsp_data, 0);
      check("t6_cnt_rst", event_count, 0);
      reset = 1'b0;
      tick(1);
      check("t6_busy2", busy, 1);
      tick(1);
      check("t6_ack", ack_toggle, 1);
      check("t6_rsp", rsp_data, 32'h1235);
      check("t6_cnt", event_count, 1);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
